dfa_ctx_matcher: RTL and testbench
==================================

Name: dfa_ctx_matcher

Overview:
- Runtime-programmable, table-driven DFA regex engine for the packet-inspection datapath.
- Successor to the fixed per-category matchers: char-class map, transition table and accept set are loaded through a config port.
- Holds NUM_CTX independent flow contexts, so interleaved streams are matched without external state save/restore.
- Sits between the packet parser (chars tagged with flow context) and the category/alert aggregator.

Parameters:
- STATE_W, 4, state width; table holds 2**STATE_W states.
- CLASS_W, 4, char-class width; 2**CLASS_W classes.
- CTX_W, 3, context-id width; NUM_CTX = 2**CTX_W.
- CNT_W, 16, match-counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  target: 0=char map, 1=transition, 2=accept, 3=reserved (write ignored)
- cfg_addr  in  STATE_W+CLASS_W  address
  - char map: [7:0] = char
  - transition: {state, class}
  - accept: [STATE_W-1:0] = state
- cfg_data  in  STATE_W  write data; low CLASS_W bits for char map, bit 0 for accept
- char_in  in  8  input character
- char_in_vld  in  1  character valid
- char_ctx  in  CTX_W  context of char_in
- state_in  in  STATE_W  state to force into a context
- state_in_vld  in  1  force strobe
- state_ctx  in  CTX_W  context written by state_in, and context read on state_out
- state_out  out  STATE_W  registered current state of state_ctx
- accept_out  out  1  match pulse
- accept_ctx  out  CTX_W  context of the match
- cnt_rd_ctx  in  CTX_W  counter read select
- cnt_out  out  CNT_W  registered match count of cnt_rd_ctx

Behaviour:
- Async reset (rst_n=0) clears:
  - all table entries and all context states to 0;
  - state_out, accept_out, accept_ctx and cnt_out to 0;
  - the pipeline valid bit.
- Stage 1 (edge after char_in_vld=1): register class = cmap[char_in], char_ctx, valid.
- Stage 2 (next cycle, combinational):
  - nxt = trans[ctx_state[ctx]][class];
  - at the following edge, write ctx_state[ctx] <= nxt, accept_out <= accept[nxt] and accept_ctx <= ctx.
- Latency:
  - accept_out is visible 2 edges after the char is sampled and is high for exactly one cycle per matching char.
  - Throughput is 1 char/cycle in any context mix.
  - Back-to-back chars in the same context need no forwarding: each stage-2 writeback lands before the next stage-2 read.
- accept_out is 0 whenever stage 2 is not valid.
- state_in_vld has precedence over character processing:
  - Same-cycle char_in_vld to the same context: the char is dropped and produces no stage-1 entry. A char to a different context proceeds normally.
  - Stage 2 targets the same context in the same cycle: the writeback and the accept are suppressed, and ctx_state takes state_in.
- state_out is registered: it shows ctx_state[state_ctx] as of the previous cycle's contents (1-cycle read latency).
- Config writes:
  - take effect at the edge and never stall the stream;
  - a lookup in the same cycle as a write to the same entry uses the old value;
  - addresses beyond a table's range are ignored.
- An out-of-range result is impossible by construction: every table index is full width.

Optional Feature:
- Macro DFA_MATCH_COUNT_EN.
- Defined:
  - per-context CNT_W-bit counter, incremented on each accept_out for accept_ctx;
  - saturates at all-ones, does not wrap;
  - state_in_vld to a context also clears its counter;
  - cnt_out <= count[cnt_rd_ctx], with 1-cycle latency.
- Not defined: no counters are built; cnt_out is tied to 0 and cnt_rd_ctx is ignored.

Test Plan:
- Load "ab": cmap['a']=1, cmap['b']=2, trans[0][1]=1, trans[1][1]=1, trans[1][2]=2, accept[2]=1, rest 0.
  - Stream "xab" on ctx 0 -> accept_out=1, accept_ctx=0 exactly 2 edges after 'b', no other pulses.
  - state_ctx=0 -> state_out=2.
- Interleave ctx3 'a', ctx5 'a', ctx3 'b', ctx5 'x' on consecutive cycles -> a single pulse with accept_ctx=3; ctx5 state returns to 0.
- Force the ctx 2 state to 1 via state_in and send 'b' to ctx 2 one cycle later -> match.
  - Same-cycle state_in_vld and 'b' to ctx 2 -> no match; state=forced value.
- Same-cycle state_in_vld to ctx 0 with ctx 0 in stage 2 holding 'b' (prior state 1) -> no pulse, ctx_state[0]=state_in.
- Assert rst_n=0 asynchronously mid-stream -> outputs are 0 immediately; after release, "ab" gives no match because the tables were cleared.
- With DFA_MATCH_COUNT_EN and CNT_W=2: 5 matches on ctx 1 -> cnt_out=3 (saturated).
  - Then state_in_vld on ctx 1 -> cnt_out=0.

Source files
------------

// File: rtl/dfa_ctx_matcher_if.sv
// dfa_ctx_matcher_if: config, character stream, state force/read and match signals of dfa_ctx_matcher
interface dfa_ctx_matcher_if #(
    parameter int STATE_W = 4,
    parameter int CLASS_W = 4,
    parameter int CTX_W   = 3,
    parameter int CNT_W   = 16
);
    logic                       cfg_we;
    logic [1:0]                 cfg_sel;
    logic [STATE_W+CLASS_W-1:0] cfg_addr;
    logic [STATE_W-1:0]         cfg_data;
    logic [7:0]                 char_in;
    logic                       char_in_vld;
    logic [CTX_W-1:0]           char_ctx;
    logic [STATE_W-1:0]         state_in;
    logic                       state_in_vld;
    logic [CTX_W-1:0]           state_ctx;
    logic [STATE_W-1:0]         state_out;
    logic                       accept_out;
    logic [CTX_W-1:0]           accept_ctx;
    logic [CTX_W-1:0]           cnt_rd_ctx;
    logic [CNT_W-1:0]           cnt_out;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data, char_in, char_in_vld, char_ctx,
               state_in, state_in_vld, state_ctx, cnt_rd_ctx,
        input  state_out, accept_out, accept_ctx, cnt_out
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_data, char_in, char_in_vld, char_ctx,
               state_in, state_in_vld, state_ctx, cnt_rd_ctx,
        output state_out, accept_out, accept_ctx, cnt_out
    );
endinterface

// File: rtl/dfa_ctx_matcher.sv
// dfa_ctx_matcher: table-driven multi-context DFA matcher; DFA_MATCH_COUNT_EN adds per-context saturating match counters
module dfa_ctx_matcher #(
    parameter int STATE_W = 4,
    parameter int CLASS_W = 4,
    parameter int CTX_W   = 3,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst_n,
    dfa_ctx_matcher_if.slave bus
);
    localparam int NUM_CTX = 2 ** CTX_W;
    localparam int NUM_ST  = 2 ** STATE_W;
    localparam int TR_N    = 2 ** (STATE_W + CLASS_W);

    logic [CLASS_W-1:0] cmap [256];
    logic [STATE_W-1:0] trans [TR_N];
    logic [NUM_ST-1:0]  acc;
    logic [STATE_W-1:0] ctx_state [NUM_CTX];
    logic               s1_vld;
    logic [CLASS_W-1:0] s1_cls;
    logic [CTX_W-1:0]   s1_ctx;
    logic [STATE_W-1:0] nxt;
    logic               wb;
    logic               cm_ok;
    logic               acc_ok;

    assign cm_ok  = (32'(bus.cfg_addr) >> 8) == 0;
    assign acc_ok = (32'(bus.cfg_addr) >> STATE_W) == 0;
    assign nxt    = trans[{ctx_state[s1_ctx], s1_cls}];
    assign wb     = s1_vld && !(bus.state_in_vld && bus.state_ctx == s1_ctx);

    // Table writes land at the edge, so a same-cycle lookup still sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) cmap[i] <= '0;
            for (int i = 0; i < TR_N; i++) trans[i] <= '0;
            acc <= '0;
        end else if (bus.cfg_we) begin
            if (bus.cfg_sel == 2'd0 && cm_ok) cmap[8'(bus.cfg_addr)] <= CLASS_W'(bus.cfg_data);
            if (bus.cfg_sel == 2'd1) trans[bus.cfg_addr] <= bus.cfg_data;
            if (bus.cfg_sel == 2'd2 && acc_ok) acc[STATE_W'(bus.cfg_addr)] <= bus.cfg_data[0];
        end
    end

    // Stage 1: classify the char; a char colliding with a force to its own context is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_cls <= '0;
            s1_ctx <= '0;
        end else begin
            s1_vld <= bus.char_in_vld && !(bus.state_in_vld && bus.state_ctx == bus.char_ctx);
            s1_cls <= cmap[bus.char_in];
            s1_ctx <= bus.char_ctx;
        end
    end

    // Stage 2 writeback; a force to the same context overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTX; i++) ctx_state[i] <= '0;
        end else begin
            if (wb) ctx_state[s1_ctx] <= nxt;
            if (bus.state_in_vld) ctx_state[bus.state_ctx] <= bus.state_in;
        end
    end

    // Registered match pulse and state readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.accept_out <= 1'b0;
            bus.accept_ctx <= '0;
            bus.state_out  <= '0;
        end else begin
            bus.accept_out <= wb && acc[nxt];
            bus.accept_ctx <= wb ? s1_ctx : bus.accept_ctx;
            bus.state_out  <= ctx_state[bus.state_ctx];
        end
    end

`ifdef DFA_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt [NUM_CTX];

    // Saturating per-context match counters, cleared by a state force to that context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTX; i++) cnt[i] <= '0;
            bus.cnt_out <= '0;
        end else begin
            if (bus.accept_out && cnt[bus.accept_ctx] != '1) cnt[bus.accept_ctx] <= cnt[bus.accept_ctx] + 1'b1;
            if (bus.state_in_vld) cnt[bus.state_ctx] <= '0;
            bus.cnt_out <= cnt[bus.cnt_rd_ctx];
        end
    end
`else
    assign bus.cnt_out = '0;
`endif
endmodule

// File: tb/tb_dfa_ctx_matcher.sv
// tb_dfa_ctx_matcher: vector-table and directed-sequence bench for dfa_ctx_matcher (DFA_MATCH_COUNT_EN aware)
module tb_dfa_ctx_matcher;
`ifdef DFA_MATCH_COUNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    typedef struct {
        bit         cv;
        logic [7:0] ch;
        int         cc;
        bit         sv;
        int         si;
        int         sc;
        bit         ea;
        int         ex;
        int         es;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t v[$];

    dfa_ctx_matcher_if #(.CNT_W(CNT_W)) bus ();

    dfa_ctx_matcher #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit cv, input logic [7:0] ch, input int cc, input bit sv, input int si, input int sc);
        bus.char_in_vld  = cv;
        bus.char_in      = ch;
        bus.char_ctx     = 3'(cc);
        bus.state_in_vld = sv;
        bus.state_in     = 4'(si);
        bus.state_ctx    = 3'(sc);
    endtask

    task automatic step(input bit cv, input logic [7:0] ch, input int cc, input bit sv, input int si, input int sc);
        drive(cv, ch, cc, sv, si, sc);
        @(negedge clk);
    endtask

    task automatic cfg(input int sel, input int addr, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 2'(sel);
        bus.cfg_addr = 8'(addr);
        bus.cfg_data = 4'(data);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic load_ab();
        cfg(0, 'h61, 1);
        cfg(0, 'h62, 2);
        cfg(1, 'h01, 1);
        cfg(1, 'h11, 1);
        cfg(1, 'h12, 2);
        cfg(2, 2, 1);
    endtask

    function automatic void add(bit cv, logic [7:0] ch, int cc, bit sv, int si, int sc, bit ea, int ex, int es);
        vec_t t;
        t.cv = cv; t.ch = ch; t.cc = cc; t.sv = sv; t.si = si; t.sc = sc;
        t.ea = ea; t.ex = ex; t.es = es;
        v.push_back(t);
    endfunction

    initial begin
        // "xab" on ctx 0
        add(1, 8'h78, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h61, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h62, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 2);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 2);
        // interleaved ctx 3 / ctx 5, watching ctx 5
        add(1, 8'h61, 3, 0, 0, 5, 0, 0, 0);
        add(1, 8'h61, 5, 0, 0, 5, 0, 0, 0);
        add(1, 8'h62, 3, 0, 0, 5, 0, 0, 0);
        add(1, 8'h78, 5, 0, 0, 5, 1, 3, 1);
        add(0, 8'h00, 0, 0, 0, 5, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 5, 0, 0, 0);
        // force ctx 2 then 'b' one cycle later
        add(0, 8'h00, 0, 1, 1, 2, 0, 0, 0);
        add(1, 8'h62, 2, 0, 0, 2, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 2, 1, 2, 1);
        add(0, 8'h00, 0, 0, 0, 2, 0, 0, 2);
        // force and 'b' to ctx 2 in the same cycle: char dropped
        add(1, 8'h62, 2, 1, 1, 2, 0, 0, 2);
        add(0, 8'h00, 0, 0, 0, 2, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 2, 0, 0, 1);
        // ctx 0 at state 1, 'b' in stage 2 while forcing ctx 0 to 3
        add(0, 8'h00, 0, 1, 1, 0, 0, 0, 2);
        add(1, 8'h62, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 3, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 3);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 3);
        // force to ctx 4 does not disturb chars of ctx 6
        add(1, 8'h61, 6, 1, 1, 4, 0, 0, 0);
        add(1, 8'h62, 6, 0, 0, 4, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 4, 1, 6, 1);
        add(0, 8'h00, 0, 0, 0, 6, 0, 0, 2);

        bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cnt_rd_ctx = '0;
        drive(0, 8'h00, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst accept_out", bus.accept_out, 0);
        chk("rst accept_ctx", bus.accept_ctx, 0);
        chk("rst state_out", bus.state_out, 0);
        chk("rst cnt_out", bus.cnt_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        load_ab();

        foreach (v[i]) begin
            drive(v[i].cv, v[i].ch, v[i].cc, v[i].sv, v[i].si, v[i].sc);
            @(negedge clk);
            chk($sformatf("v%0d accept_out", i), bus.accept_out, v[i].ea);
            if (v[i].ea) chk($sformatf("v%0d accept_ctx", i), bus.accept_ctx, v[i].ex);
            chk($sformatf("v%0d state_out", i), bus.state_out, v[i].es);
        end

        // reserved target write must not alter trans[1][2]
        drive(0, 8'h00, 0, 0, 0, 0);
        cfg(3, 'h12, 0);
        step(0, 8'h00, 0, 1, 1, 1);
        step(1, 8'h62, 1, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("reserved write ignored", bus.accept_out, 1);

        // lookup concurrent with a write to the same entry sees the old value
        step(0, 8'h00, 0, 1, 1, 1);
        step(1, 8'h62, 1, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 0, 1);
        cfg(1, 'h12, 0);
        chk("same-cycle write old value", bus.accept_out, 1);
        step(0, 8'h00, 0, 1, 1, 1);
        step(1, 8'h62, 1, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("written entry new value", bus.accept_out, 0);

        // async reset mid-stream
        drive(0, 8'h00, 0, 0, 0, 7);
        cfg(1, 'h12, 2);
        step(0, 8'h00, 0, 1, 1, 7);
        step(1, 8'h62, 7, 0, 0, 7);
        step(1, 8'h61, 7, 0, 0, 7);
        chk("pre-reset accept_out", bus.accept_out, 1);
        chk("pre-reset accept_ctx", bus.accept_ctx, 7);
        chk("pre-reset state_out", bus.state_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst accept_out", bus.accept_out, 0);
        chk("async rst accept_ctx", bus.accept_ctx, 0);
        chk("async rst state_out", bus.state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h61, 0, 0, 0, 0);
        step(1, 8'h62, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("cleared tables no match", bus.accept_out, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("cleared tables no match 2", bus.accept_out, 0);
        chk("cleared tables state_out", bus.state_out, 0);

        // match counter on ctx 1
        load_ab();
        bus.cnt_rd_ctx = 3'd1;
        step(1, 8'h61, 1, 0, 0, 0);
        step(1, 8'h62, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 8'h61, 1, 0, 0, 0);
            step(1, 8'h61, 1, 0, 0, 0);
            step(1, 8'h62, 1, 0, 0, 0);
        end
        repeat (3) step(0, 8'h00, 0, 0, 0, 0);
`ifdef DFA_MATCH_COUNT_EN
        chk("cnt saturated", bus.cnt_out, 3);
        step(0, 8'h00, 0, 1, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("cnt cleared by force", bus.cnt_out, 0);
`else
        chk("cnt tied off", bus.cnt_out, 0);
`endif
        chk("cnt path ctx1 state_out", bus.state_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
